lp805x_sfrbus_port: RTL and testbench



---
 rtl/lp805x_sfrbus_port.sv | 127 ++++++++++++
 tb/tb_lp805x_sfrbus_port.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lp805x_sfrbus_port.sv
// lp805x_sfrbus_port
// SFR bus port: a one-entry command slot decoded into SFR read/write strobes,
// a response capture register, and a one-entry response slot.
// All handshake flags come straight from registers, so no input reaches them
// through combinational logic.
module lp805x_sfrbus_port (
    input  logic        clk,
    input  logic        rst,

    // command slot
    input  logic [28:0] cmd_bus,
    input  logic        cmd_put,
    output logic        cmd_wrdy,
    input  logic        cmd_get,
    output logic        cmd_rrdy,

    // decoded command
    output logic        wr,
    output logic        rd,
    output logic        wr_bit,
    output logic        rd_bit,
    output logic [7:0]  wr_addr,
    output logic [7:0]  rd_addr,
    output logic [7:0]  data_in,
    output logic        bit_in,

    // response capture
    input  logic [7:0]  rsp_data,
    input  logic        rsp_bit,
    input  logic        rsp_load,
    output logic [8:0]  rsp_bus,

    // response slot
    input  logic        rsp_put,
    output logic        rsp_wrdy,
    input  logic        rsp_get,
    output logic        rsp_rrdy,
    output logic [8:0]  rsp_q
);

    // Command slot state
    logic [28:0] cmd_q;
    logic [28:0] cmd_d;
    logic        cmd_valid_q;
    logic        cmd_valid_d;

    // Response register and response slot state
    logic [8:0]  rsp_bus_q;
    logic [8:0]  rsp_bus_d;
    logic [8:0]  rsp_slot_q;
    logic [8:0]  rsp_slot_d;
    logic        rsp_valid_q;
    logic        rsp_valid_d;

    // Command slot next state: load only when empty; a put while full is
    // dropped even if the same edge pops the slot.
    always_comb begin
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        if (!cmd_valid_q && cmd_put) begin
            cmd_d       = cmd_bus;
            cmd_valid_d = 1'b1;
        end else if (cmd_valid_q && cmd_get) begin
            cmd_valid_d = 1'b0;
        end
    end

    // Response capture register: holds unless explicitly loaded.
    always_comb begin
        rsp_bus_d = rsp_bus_q;
        if (rsp_load) begin
            rsp_bus_d = {rsp_data, rsp_bit};
        end
    end

    // Response slot next state: same put/get rules as the command slot,
    // sourced from the registered response, so a same-cycle load+put
    // captures the value held before the load.
    always_comb begin
        rsp_slot_d  = rsp_slot_q;
        rsp_valid_d = rsp_valid_q;
        if (!rsp_valid_q && rsp_put) begin
            rsp_slot_d  = rsp_bus_q;
            rsp_valid_d = 1'b1;
        end else if (rsp_valid_q && rsp_get) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            rsp_bus_q   <= '0;
            rsp_slot_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            rsp_bus_q   <= rsp_bus_d;
            rsp_slot_q  <= rsp_slot_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Handshake flags are pure register outputs.
    assign cmd_rrdy = cmd_valid_q;
    assign cmd_wrdy = ~cmd_valid_q;
    assign rsp_rrdy = rsp_valid_q;
    assign rsp_wrdy = ~rsp_valid_q;

    // Strobes are qualified by valid so a popped word issues nothing;
    // address/data fields are left raw from the held word.
    assign wr      = cmd_q[28] & cmd_valid_q;
    assign rd      = cmd_q[27] & cmd_valid_q;
    assign wr_bit  = cmd_q[26] & cmd_valid_q;
    assign rd_bit  = cmd_q[25] & cmd_valid_q;
    assign wr_addr = cmd_q[24:17];
    assign rd_addr = cmd_q[16:9];
    assign data_in = cmd_q[8:1];
    assign bit_in  = cmd_q[0];

    assign rsp_bus = rsp_bus_q;
    assign rsp_q   = rsp_slot_q;

endmodule

// File: tb/tb_lp805x_sfrbus_port.sv
// Directed testbench for lp805x_sfrbus_port.
module tb_lp805x_sfrbus_port;

    logic        clk;
    logic        rst;
    logic [28:0] cmd_bus;
    logic        cmd_put;
    logic        cmd_wrdy;
    logic        cmd_get;
    logic        cmd_rrdy;
    logic        wr;
    logic        rd;
    logic        wr_bit;
    logic        rd_bit;
    logic [7:0]  wr_addr;
    logic [7:0]  rd_addr;
    logic [7:0]  data_in;
    logic        bit_in;
    logic [7:0]  rsp_data;
    logic        rsp_bit;
    logic        rsp_load;
    logic [8:0]  rsp_bus;
    logic        rsp_put;
    logic        rsp_wrdy;
    logic        rsp_get;
    logic        rsp_rrdy;
    logic [8:0]  rsp_q;

    int pass_cnt;
    int total_cnt;
    int fail_cnt;

    logic [28:0] word_a;
    logic [28:0] word_b;

    lp805x_sfrbus_port dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_bus  (cmd_bus),
        .cmd_put  (cmd_put),
        .cmd_wrdy (cmd_wrdy),
        .cmd_get  (cmd_get),
        .cmd_rrdy (cmd_rrdy),
        .wr       (wr),
        .rd       (rd),
        .wr_bit   (wr_bit),
        .rd_bit   (rd_bit),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .data_in  (data_in),
        .bit_in   (bit_in),
        .rsp_data (rsp_data),
        .rsp_bit  (rsp_bit),
        .rsp_load (rsp_load),
        .rsp_bus  (rsp_bus),
        .rsp_put  (rsp_put),
        .rsp_wrdy (rsp_wrdy),
        .rsp_get  (rsp_get),
        .rsp_rrdy (rsp_rrdy),
        .rsp_q    (rsp_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure with tag/observed/expected.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs changed afterwards are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        fail_cnt  = 0;
        rst      = 1'b1;
        cmd_bus  = '0;
        cmd_put  = 1'b0;
        cmd_get  = 1'b0;
        rsp_data = '0;
        rsp_bit  = 1'b0;
        rsp_load = 1'b0;
        rsp_put  = 1'b0;
        rsp_get  = 1'b0;
        // wr=1, wr_addr=8C, rd_addr=00, data=A5, bit=0
        word_a = {1'b1, 1'b0, 1'b0, 1'b0, 8'h8C, 8'h00, 8'hA5, 1'b0};
        // rd=1, rd_bit=1, wr_addr=00, rd_addr=90, data=00, bit=1
        word_b = {1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h90, 8'h00, 1'b1};

        // Reset then idle
        step();
        step();
        rst = 1'b0;
        step();
        $display("txn reset/idle");
        check("rst_cmd_wrdy", 32'(cmd_wrdy), 32'h1);
        check("rst_cmd_rrdy", 32'(cmd_rrdy), 32'h0);
        check("rst_rsp_wrdy", 32'(rsp_wrdy), 32'h1);
        check("rst_rsp_bus",  32'(rsp_bus),  32'h000);
        check("rst_wr",       32'(wr),       32'h0);
        check("rst_rd",       32'(rd),       32'h0);

        // Command put of a write word
        cmd_bus = word_a;
        cmd_put = 1'b1;
        step();
        cmd_put = 1'b0;
        $display("txn cmd_put word_a");
        check("put_cmd_rrdy", 32'(cmd_rrdy), 32'h1);
        check("put_cmd_wrdy", 32'(cmd_wrdy), 32'h0);
        check("put_wr",       32'(wr),       32'h1);
        check("put_rd",       32'(rd),       32'h0);
        check("put_wr_addr",  32'(wr_addr),  32'h8C);
        check("put_data_in",  32'(data_in),  32'hA5);
        check("put_bit_in",   32'(bit_in),   32'h0);

        // Put while full (no get) is ignored
        cmd_bus = word_b;
        cmd_put = 1'b1;
        step();
        cmd_put = 1'b0;
        $display("txn cmd_put while full");
        check("full_wr_addr", 32'(wr_addr), 32'h8C);
        check("full_rd",      32'(rd),      32'h0);

        // Pop
        cmd_get = 1'b1;
        step();
        cmd_get = 1'b0;
        $display("txn cmd_get");
        check("get_wr",       32'(wr),       32'h0);
        check("get_cmd_rrdy", 32'(cmd_rrdy), 32'h0);
        check("get_cmd_wrdy", 32'(cmd_wrdy), 32'h1);
        check("get_wr_addr",  32'(wr_addr),  32'h8C);

        // Get on empty slot has no effect
        cmd_get = 1'b1;
        step();
        cmd_get = 1'b0;
        $display("txn cmd_get while empty");
        check("eget_cmd_wrdy", 32'(cmd_wrdy), 32'h1);

        // Fill, then put+get together: new word dropped
        cmd_bus = word_a;
        cmd_put = 1'b1;
        step();
        cmd_bus = word_b;
        cmd_get = 1'b1;
        step();
        cmd_put = 1'b0;
        cmd_get = 1'b0;
        $display("txn cmd_put+cmd_get while full");
        check("pg_cmd_rrdy", 32'(cmd_rrdy), 32'h0);
        check("pg_wr_addr",  32'(wr_addr),  32'h8C);
        check("pg_rd_addr",  32'(rd_addr),  32'h00);
        check("pg_bit_in",   32'(bit_in),   32'h0);
        check("pg_rd",       32'(rd),       32'h0);

        // Next put captures word_b
        cmd_put = 1'b1;
        step();
        cmd_put = 1'b0;
        $display("txn cmd_put word_b");
        check("b_rd",      32'(rd),      32'h1);
        check("b_rd_bit",  32'(rd_bit),  32'h1);
        check("b_wr",      32'(wr),      32'h0);
        check("b_wr_bit",  32'(wr_bit),  32'h0);
        check("b_rd_addr", 32'(rd_addr), 32'h90);
        check("b_wr_addr", 32'(wr_addr), 32'h00);
        check("b_bit_in",  32'(bit_in),  32'h1);

        // Response load
        rsp_data = 8'h3C;
        rsp_bit  = 1'b1;
        rsp_load = 1'b1;
        step();
        rsp_load = 1'b0;
        rsp_data = 8'hFF;
        rsp_bit  = 1'b0;
        $display("txn rsp_load 3C/1");
        check("load_rsp_bus", 32'(rsp_bus), 32'h079);
        step();
        $display("txn rsp hold");
        check("hold_rsp_bus", 32'(rsp_bus), 32'h079);

        // Response put
        rsp_put = 1'b1;
        step();
        rsp_put = 1'b0;
        $display("txn rsp_put");
        check("rput_rsp_rrdy", 32'(rsp_rrdy), 32'h1);
        check("rput_rsp_wrdy", 32'(rsp_wrdy), 32'h0);
        check("rput_rsp_q",    32'(rsp_q),    32'h079);

        // Response get
        rsp_get = 1'b1;
        step();
        rsp_get = 1'b0;
        $display("txn rsp_get");
        check("rget_rsp_rrdy", 32'(rsp_rrdy), 32'h0);

        // Load and put together: slot takes the old register value
        rsp_data = 8'h55;
        rsp_bit  = 1'b0;
        rsp_load = 1'b1;
        rsp_put  = 1'b1;
        step();
        rsp_load = 1'b0;
        rsp_put  = 1'b0;
        $display("txn rsp_load+rsp_put");
        check("lp_rsp_q",    32'(rsp_q),    32'h079);
        check("lp_rsp_bus",  32'(rsp_bus),  32'h0AA);
        check("lp_rsp_rrdy", 32'(rsp_rrdy), 32'h1);

        // Asynchronous reset while both slots are full
        #2;
        rst = 1'b1;
        #2;
        $display("txn async reset");
        check("ar_cmd_rrdy", 32'(cmd_rrdy), 32'h0);
        check("ar_cmd_wrdy", 32'(cmd_wrdy), 32'h1);
        check("ar_rsp_rrdy", 32'(rsp_rrdy), 32'h0);
        check("ar_rsp_wrdy", 32'(rsp_wrdy), 32'h1);
        check("ar_rsp_q",    32'(rsp_q),    32'h000);
        check("ar_rsp_bus",  32'(rsp_bus),  32'h000);
        check("ar_rd",       32'(rd),       32'h0);
        check("ar_rd_addr",  32'(rd_addr),  32'h00);
        check("ar_bit_in",   32'(bit_in),   32'h0);
        step();
        rst = 1'b0;

        // First put after reset
        cmd_bus = word_a;
        cmd_put = 1'b1;
        step();
        cmd_put = 1'b0;
        $display("txn cmd_put after reset");
        check("pr_cmd_rrdy", 32'(cmd_rrdy), 32'h1);
        check("pr_wr",       32'(wr),       32'h1);
        check("pr_data_in",  32'(data_in),  32'hA5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
